// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute-stage issue logic and the
// iterative multiply/divide unit.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (output start, op, A, B, input busy, done, HI, LO);
   modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Works on operand magnitudes and applies the result signs in a final fix-up cycle.
module muldiv_unit #(
   parameter int unsigned     WIDTH   = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = WIDTH'(32'hFFFF_FFFF)
) (
   input logic      clk,
   input logic      reset,
   muldiv_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    count;
   logic [PW-1:0]    prod;       // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0] mcand;      // multiplicand or divisor magnitude
   logic             is_div, neg_res, neg_rem, div0;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic             sgn_c, a_neg_c, b_neg_c, accept_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;
   logic [WIDTH:0]   sum_c, shifted_c, diff_c;
   logic [PW-1:0]    prod_neg_c;

   assign sgn_c   = ~bus.op[0];
   assign a_neg_c = sgn_c & bus.A[WIDTH-1];
   assign b_neg_c = sgn_c & bus.B[WIDTH-1];
   assign a_mag_c = a_neg_c ? -bus.A : bus.A;
   assign b_mag_c = b_neg_c ? -bus.B : bus.B;

   assign sum_c      = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
   assign shifted_c  = {prod[PW-1:WIDTH], prod[WIDTH-1]};
   assign diff_c     = shifted_c - {1'b0, mcand};
   assign prod_neg_c = -prod;

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

   // Next-state decode
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      unique case (state)
         IDLE: if (bus.start && !bus.op[2]) begin
            accept_c  = 1'b1;
            state_nxt = CALC;
         end
         CALC: if (count == CW'(WIDTH - 1)) state_nxt = FIX;
         FIX:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         prod    <= '0;
         mcand   <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state  <= state_nxt;
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept_c) begin
                  is_div  <= bus.op[1];
                  neg_res <= a_neg_c ^ b_neg_c;
                  neg_rem <= a_neg_c;
                  div0    <= (bus.B == '0);
                  mcand   <= bus.op[1] ? b_mag_c : a_mag_c;
                  prod    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag_c : b_mag_c)};
                  count   <= '0;
                  busy_q  <= 1'b1;
               end else if (bus.start && bus.op == OP_MTHI) begin
                  hi_q <= bus.A;
               end else if (bus.start && bus.op == OP_MTLO) begin
                  lo_q <= bus.A;
               end
            end
            CALC: begin
               count <= count + 1'b1;
               if (!is_div)
                  prod <= {sum_c, prod[WIDTH-1:1]};
               else if (diff_c[WIDTH])
                  prod <= {shifted_c[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
               else
                  prod <= {diff_c[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
            end
            FIX: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               if (is_div) begin
                  // With a zero divisor the remainder ends up as |A|, so signing it restores raw A
                  hi_q <= neg_rem ? -prod[PW-1:WIDTH] : prod[PW-1:WIDTH];
                  lo_q <= div0 ? DIV0_LO : (neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);
               end else begin
                  hi_q <= neg_res ? prod_neg_c[PW-1:WIDTH] : prod[PW-1:WIDTH];
                  lo_q <= neg_res ? prod_neg_c[WIDTH-1:0] : prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops vs. an
// arithmetic reference model, and hand sequences for timing/reset/busy corners.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   muldiv_if #(.WIDTH(32)) bus ();
   muldiv_unit #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endfunction

   // Reference results straight from the arithmetic definitions
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = 'x; lo = 'x;
      case (op)
         3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
         3'd2, 3'd3: begin
            if (b == 0) begin
               hi = a; lo = 32'hFFFF_FFFF;
            end else if (op == 3'd2) begin
               q = sa / sb; r = sa % sb;
               p = 64'(q); lo = p[31:0];
               p = 64'(r); hi = p[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   // Issue one mult/div, wait for done (bounded), report latency and busy behaviour
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit busy_ok);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
      lat = 0; busy_ok = 1'b1;
      while (!bus.done && lat < 60) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (bus.busy) busy_ok = 1'b0;
      if (!bus.done) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: op=%0d no done within %0d cycles", op, lat);
      end
   endtask

   vec_t        vecs[$];
   logic [31:0] ehi, elo;
   int          lat, dcount;
   bit          bok;

   initial begin
      bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hi", bus.HI, 0);
      check("reset_lo", bus.LO, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      @(negedge clk); reset = 1'b0;

      vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
      vecs.push_back('{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
      vecs.push_back('{3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd0,         32'd21});
      vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{3'd3, 32'd7,         32'd2,         32'd1,         32'd3});
      vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
      vecs.push_back('{3'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF});
      vecs.push_back('{3'd2, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF});
      vecs.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
         check($sformatf("vec%0d_hi", i), bus.HI, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), bus.LO, vecs[i].lo);
         check($sformatf("vec%0d_latency", i), 64'(lat), 33);
         check($sformatf("vec%0d_busy", i), 64'(bok), 1);
      end
      @(posedge clk); #1;
      check("done_one_cycle", bus.done, 0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         model(op, a, b, ehi, elo);
         run_op(op, a, b, lat, bok);
         check($sformatf("rnd%0d_op%0d_hi", i, op), bus.HI, ehi);
         check($sformatf("rnd%0d_op%0d_lo", i, op), bus.LO, elo);
      end

      // MTHI/MTLO while idle, and an undefined op
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'hCAFE;
      @(posedge clk); #1;
      check("mthi_hi", bus.HI, 32'hCAFE);
      check("mthi_busy", bus.busy, 0);
      check("mthi_done", bus.done, 0);
      bus.op = 3'b101; bus.A = 32'hBEEF;
      @(posedge clk); #1;
      check("mtlo_lo", bus.LO, 32'hBEEF);
      check("mtlo_hi_kept", bus.HI, 32'hCAFE);
      bus.op = 3'b110; bus.A = 32'h1111;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("undef_hi", bus.HI, 32'hCAFE);
      check("undef_lo", bus.LO, 32'hBEEF);
      check("undef_busy", bus.busy, 0);

      // Starts during a DIV are ignored
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'hFFFF_FF9C; bus.B = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd9; bus.B = 32'd9;
      @(negedge clk);
      bus.op = 3'b101; bus.A = 32'h5555;
      @(negedge clk);
      bus.start = 1'b0;
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (bus.done) dcount++;
      end
      model(3'd2, 32'hFFFF_FF9C, 32'd7, ehi, elo);
      check("busy_ignore_hi", bus.HI, ehi);
      check("busy_ignore_lo", bus.LO, elo);
      check("busy_ignore_dones", 64'(dcount), 1);
      check("busy_ignore_idle", bus.busy, 0);

      // Reset in the middle of a MULT aborts it
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd5; bus.B = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      bus.start = 1'b1; bus.op = 3'd1; bus.A = 32'd4; bus.B = 32'd4;
      @(posedge clk); #1;
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_hi", bus.HI, 0);
      check("rst_mid_lo", bus.LO, 0);
      check("rst_mid_done", bus.done, 0);
      @(negedge clk);
      reset = 1'b0; bus.start = 1'b0;
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dcount++;
      end
      check("rst_no_resume", 64'(dcount), 0);
      run_op(3'd1, 32'd2, 32'd3, lat, bok);
      check("post_rst_lo", bus.LO, 6);
      check("post_rst_hi", bus.HI, 0);
      check("post_rst_latency", 64'(lat), 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
